// File: rtl/qk_stream_tx.sv
// Query/key vector transmitter: holds one Q and one K vector and streams them
// interleaved (Q0, K0, Q1, K1, ...) over an 8-bit valid/ready master port.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; buffers writable; stream quiet
// SEND  | presenting beat cnt; advance on each handshake; buffers locked
// DONE  | one-cycle completion pulse, then back to IDLE
module qk_stream_tx #(
    parameter int N_FEAT = 4,
    parameter int W      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(N_FEAT)-1:0] wr_idx,
    input  logic [W-1:0]              wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [W-1:0]              data_out,
    output logic                      vld_out,
    input  logic                      rdy_in
);

    localparam int CW = $clog2(2 * N_FEAT);
    localparam logic [CW-1:0] LAST_BEAT = CW'(2 * N_FEAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [W-1:0]  q_buf [N_FEAT];
    logic [W-1:0]  k_buf [N_FEAT];
    logic          hs;
    logic [CW-2:0] rd_idx;

    assign hs     = vld_out & rdy_in;
    assign rd_idx = cnt[CW-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vld_out   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SEND;
            end
            S_SEND: begin
                vld_out = 1'b1;
                busy    = 1'b1;
                if (rdy_in && cnt == LAST_BEAT) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cnt <= '0;
        end else if (hs) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Buffers are frozen for the whole transfer so the stream cannot tear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FEAT; i++) begin
                q_buf[i] <= '0;
                k_buf[i] <= '0;
            end
        end else if (wr_en && !busy) begin
            if (wr_sel) k_buf[wr_idx] <= wr_data;
            else        q_buf[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        data_out = '0;
        if (state == S_SEND) begin
            data_out = cnt[0] ? k_buf[rd_idx] : q_buf[rd_idx];
        end
    end

endmodule

// File: tb/tb_qk_stream_tx.sv
// Self-checking bench for qk_stream_tx: scenario tasks compare the observed
// stream against an interleaved Q/K reference built from the loaded vectors.
module tb_qk_stream_tx;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          wr_sel;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  data_out;
    logic          vld_out;
    logic          rdy_in;

    qk_stream_tx #(.N_FEAT(N), .W(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
        .wr_data(wr_data), .start(start), .busy(busy), .done(done),
        .data_out(data_out), .vld_out(vld_out), .rdy_in(rdy_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] mq [N];
    logic [W-1:0] mk [N];

    logic [W-1:0] got_q [$];
    int ndone, stall_err, busy_err, extra_vld, done_cyc, last_hs;
    bit timed_out;
    logic first_vld;
    logic [W-1:0] first_data;

    function automatic logic [W-1:0] exp_beat(input int i);
        return (i % 2 == 1) ? mk[i / 2] : mq[i / 2];
    endfunction

    task automatic load(input bit sel, input int idx, input logic [W-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_idx = IW'(idx); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) mk[idx] = d; else mq[idx] = d;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin mq[i] = '0; mk[i] = '0; end
    endtask

    // Starts a transfer and records every handshake; mode 0 = always ready,
    // 1 = ready pattern 1,0,0,1,0,1 repeating, 2 = random ready.
    task automatic run_xfer(input int mode, input int lock_at, input int max_cyc);
        int cyc, post, pat_i;
        bit stalled, r;
        logic [W-1:0] prev;
        int pat [6];
        pat = '{1, 0, 0, 1, 0, 1};
        got_q.delete();
        ndone = 0; stall_err = 0; busy_err = 0; extra_vld = 0;
        done_cyc = -1; last_hs = -1; timed_out = 0;
        cyc = 0; post = 0; pat_i = 0; stalled = 0; prev = '0;
        start = 1'b1;
        @(negedge clk);
        first_vld = vld_out; first_data = data_out;
        forever begin
            wr_en = 1'b0; start = 1'b0;
            if (done_cyc >= 0 && vld_out) extra_vld++;
            if (done === 1'b1) begin ndone++; if (done_cyc < 0) done_cyc = cyc; end
            if (busy !== vld_out) busy_err++;
            if (vld_out !== 1'b1 && data_out !== '0) stall_err++;
            if (stalled && (vld_out !== 1'b1 || data_out !== prev)) stall_err++;
            if (vld_out === 1'b1) begin
                case (mode)
                    0: r = 1'b1;
                    1: begin r = pat[pat_i % 6] != 0; pat_i++; end
                    default: r = ($urandom % 2) == 1;
                endcase
                rdy_in = r;
                if (r) begin got_q.push_back(data_out); last_hs = cyc; end
                stalled = !r;
                prev = data_out;
            end else begin
                rdy_in = ($urandom % 2) == 1;
                stalled = 1'b0;
            end
            if (cyc == lock_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_idx = IW'(1); wr_data = 8'h55; start = 1'b1;
            end
            if (done_cyc >= 0) post++;
            if (post > 2) break;
            if (cyc >= max_cyc) begin timed_out = 1; break; end
            cyc++;
            @(negedge clk);
        end
        rdy_in = 1'b0; wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({vld_out, busy, done, data_out} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: vld=%b busy=%b done=%b data=%h, required all 0",
                         i, vld_out, busy, done, data_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] qv [N];
        logic [W-1:0] kv [N];
        qv = '{8'h40, 8'hC0, 8'h20, 8'h01};
        kv = '{8'h10, 8'h7F, 8'h80, 8'hFF};
        for (int i = 0; i < N; i++) begin load(0, i, qv[i]); load(1, i, kv[i]); end
        run_xfer(0, -1, 100);
        n_checks++;
        if (timed_out || first_vld !== 1'b1 || first_data !== 8'h40) begin
            n_fail++;
            $display("FAIL basic_latency: to=%0d vld=%b data=%h, required vld=1 data=40", timed_out, first_vld, first_data);
        end
        n_checks++;
        if (got_q.size() != 2 * N) begin
            n_fail++;
            $display("FAIL basic_count: %0d beats, required %0d", got_q.size(), 2 * N);
        end
        for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (got_q[i] !== exp_beat(i)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got %h, required %h", i, got_q[i], exp_beat(i));
            end
        end
        n_checks++;
        if (ndone != 1 || done_cyc != 2 * N || busy_err != 0 || stall_err != 0 || extra_vld != 0) begin
            n_fail++;
            $display("FAIL basic_done: ndone=%0d done_cyc=%0d busy_err=%0d hold_err=%0d extra=%0d, required 1,%0d,0,0,0",
                     ndone, done_cyc, busy_err, stall_err, extra_vld, 2 * N);
        end
    endtask

    task automatic test_backpressure();
        run_xfer(1, -1, 200);
        n_checks++;
        if (timed_out || got_q.size() != 2 * N) begin
            n_fail++;
            $display("FAIL bp_count: to=%0d beats=%0d, required 0,%0d", timed_out, got_q.size(), 2 * N);
        end
        for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (got_q[i] !== exp_beat(i)) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got %h, required %h", i, got_q[i], exp_beat(i));
            end
        end
        n_checks++;
        if (stall_err != 0 || busy_err != 0 || ndone != 1 || done_cyc != last_hs + 1) begin
            n_fail++;
            $display("FAIL bp_hold: hold_err=%0d busy_err=%0d ndone=%0d done_cyc=%0d last_hs=%0d, required 0,0,1,last_hs+1",
                     stall_err, busy_err, ndone, done_cyc, last_hs);
        end
    endtask

    task automatic test_busy_lockout();
        run_xfer(0, 3, 100);
        n_checks++;
        if (timed_out || got_q.size() != 2 * N || ndone != 1 || extra_vld != 0) begin
            n_fail++;
            $display("FAIL lock_xfer: to=%0d beats=%0d ndone=%0d extra=%0d, required 0,%0d,1,0",
                     timed_out, got_q.size(), ndone, extra_vld, 2 * N);
        end
        for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (got_q[i] !== exp_beat(i)) begin
                n_fail++;
                $display("FAIL lock_beat%0d: got %h, required %h", i, got_q[i], exp_beat(i));
            end
        end
        n_checks++;
        if (vld_out !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_restart: vld=%b busy=%b, required 0,0", vld_out, busy);
        end
        run_xfer(0, -1, 100);
        n_checks++;
        if (got_q.size() < 3 || got_q[2] !== 8'hC0) begin
            n_fail++;
            $display("FAIL lock_q1: beats=%0d q1=%h, required C0", got_q.size(), (got_q.size() > 2) ? got_q[2] : 8'hxx);
        end
    endtask

    task automatic test_write_with_start();
        wr_en = 1'b1; wr_sel = 1'b1; wr_idx = '0; wr_data = 8'h33;
        mk[0] = 8'h33;
        run_xfer(0, -1, 100);
        n_checks++;
        if (got_q.size() != 2 * N || got_q[1] !== 8'h33) begin
            n_fail++;
            $display("FAIL wr_start: beats=%0d beat1=%h, required %0d,33", got_q.size(),
                     (got_q.size() > 1) ? got_q[1] : 8'hxx, 2 * N);
        end
        for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (got_q[i] !== exp_beat(i)) begin
                n_fail++;
                $display("FAIL wr_start_beat%0d: got %h, required %h", i, got_q[i], exp_beat(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        start = 1'b1; rdy_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (vld_out !== 1'b1 || data_out !== exp_beat(i)) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: vld=%b data=%h, required 1,%h", i, vld_out, data_out, exp_beat(i));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rdy_in = 1'b0;
        model_clear();
        n_checks++;
        if (vld_out !== 1'b0 || data_out !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_out: vld=%b data=%h busy=%b, required 0,00,0", vld_out, data_out, busy);
        end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1 || vld_out === 1'b1) seen_done = 1;
            @(negedge clk);
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL rstmid_done: done or vld seen after reset, required none");
        end
        run_xfer(0, -1, 100);
        n_checks++;
        if (got_q.size() != 2 * N) begin
            n_fail++;
            $display("FAIL rstmid_count: %0d beats, required %0d", got_q.size(), 2 * N);
        end
        for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
            n_checks++;
            if (got_q[i] !== 8'h00) begin
                n_fail++;
                $display("FAIL rstmid_zero%0d: got %h, required 00", i, got_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 6; j++)
                load($urandom % 2, $urandom_range(0, N - 1), W'($urandom));
            run_xfer(2, -1, 400);
            n_checks++;
            if (timed_out || got_q.size() != 2 * N || ndone != 1 || stall_err != 0 || busy_err != 0 ||
                done_cyc != last_hs + 1) begin
                n_fail++;
                $display("FAIL rand%0d_proto: to=%0d beats=%0d ndone=%0d hold=%0d busy=%0d done_cyc=%0d last_hs=%0d",
                         it, timed_out, got_q.size(), ndone, stall_err, busy_err, done_cyc, last_hs);
            end
            for (int i = 0; i < got_q.size() && i < 2 * N; i++) begin
                n_checks++;
                if (got_q[i] !== exp_beat(i)) begin
                    n_fail++;
                    $display("FAIL rand%0d_beat%0d: got %h, required %h", it, i, got_q[i], exp_beat(i));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_idx = '0; wr_data = '0;
        start = 1'b0; rdy_in = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_lockout();
        test_write_with_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
